// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: FSM state encodings, UART command bytes
// and the decoded command bundle.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  localparam logic [7:0] ASCII_RUN_UC  = 8'h52;  // 'R'
  localparam logic [7:0] ASCII_RUN_LC  = 8'h72;  // 'r'
  localparam logic [7:0] ASCII_CLR_UC  = 8'h43;  // 'C'
  localparam logic [7:0] ASCII_CLR_LC  = 8'h63;  // 'c'
  localparam logic [7:0] ASCII_VIEW_UC = 8'h4E;  // 'N'
  localparam logic [7:0] ASCII_VIEW_LC = 8'h6E;  // 'n'
  localparam logic [7:0] ASCII_SRC_UC  = 8'h4D;  // 'M'
  localparam logic [7:0] ASCII_SRC_LC  = 8'h6D;  // 'm'

  typedef struct packed {
    logic clr;
    logic run;
    logic view;
    logic src;
  } cmd_t;

endpackage

// File: rtl/stopwatch_cu_if.sv
// Button/UART command inputs and control outputs of the stopwatch control unit.
interface stopwatch_cu_if;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_mode;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       o_run;
  logic       o_clear;
  logic       o_disp_sel;
  logic       o_src_sel;
  logic [1:0] o_state;

  modport master (
    output btn_run, btn_clear, btn_mode, rx_data, rx_done,
    input  o_run, o_clear, o_disp_sel, o_src_sel, o_state
  );

  modport slave (
    input  btn_run, btn_clear, btn_mode, rx_data, rx_done,
    output o_run, o_clear, o_disp_sel, o_src_sel, o_state
  );
endinterface

// File: rtl/stopwatch_cu_cmd_decoder.sv
// Merges button pulses and UART bytes into at most one command per cycle,
// priority CLR > RUN_TGL > VIEW_TGL > SRC_TGL.
module cmd_decoder
  import stopwatch_pkg::*;
(
  input  logic       btn_run_i,
  input  logic       btn_clear_i,
  input  logic       btn_mode_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output cmd_t       cmd_o
);

  logic raw_run, raw_clr, raw_view, raw_src;

  assign raw_run  = btn_run_i   | (rx_done_i & ((rx_data_i == ASCII_RUN_UC)  | (rx_data_i == ASCII_RUN_LC)));
  assign raw_clr  = btn_clear_i | (rx_done_i & ((rx_data_i == ASCII_CLR_UC)  | (rx_data_i == ASCII_CLR_LC)));
  assign raw_view = btn_mode_i  | (rx_done_i & ((rx_data_i == ASCII_VIEW_UC) | (rx_data_i == ASCII_VIEW_LC)));
  assign raw_src  = rx_done_i & ((rx_data_i == ASCII_SRC_UC) | (rx_data_i == ASCII_SRC_LC));

  always_comb begin
    cmd_o = '0;
    if (raw_clr)       cmd_o.clr  = 1'b1;
    else if (raw_run)  cmd_o.run  = 1'b1;
    else if (raw_view) cmd_o.view = 1'b1;
    else if (raw_src)  cmd_o.src  = 1'b1;
  end

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: STOP/RUN/CLEAR FSM, view/source toggles and a
// post-command lockout window that drops (never queues) further commands.
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int CMD_GAP = 100_000
) (
  input  logic          clk,
  input  logic          reset,
  stopwatch_cu_if.slave bus
);

  // A one-bit counter is kept for CMD_GAP=1; it is only ever loaded with 0.
  localparam int              GAP_W    = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CMD_GAP - 1);

  cmd_t             cmd;
  logic             accept;
  logic [GAP_W-1:0] gap_q, gap_d;
  state_e           state_q;
  logic             run_q, clear_q, disp_q, src_q;

  cmd_decoder u_cmd_decoder (
    .btn_run_i   (bus.btn_run),
    .btn_clear_i (bus.btn_clear),
    .btn_mode_i  (bus.btn_mode),
    .rx_data_i   (bus.rx_data),
    .rx_done_i   (bus.rx_done),
    .cmd_o       (cmd)
  );

  assign accept = (gap_q == '0) && (cmd != '0);

  always_comb begin
    gap_d = gap_q;
    if (accept)
      gap_d = GAP_LOAD;
    else if (gap_q != '0)
      gap_d = gap_q - GAP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
      disp_q  <= 1'b0;
      src_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      gap_q   <= gap_d;
      clear_q <= 1'b0;
      if (accept && cmd.view) disp_q <= ~disp_q;
      if (accept && cmd.src)  src_q  <= ~src_q;
      case (state_q)
        ST_STOP: begin
          run_q <= 1'b0;
          if (accept && cmd.clr) begin
            state_q <= ST_CLEAR;
            clear_q <= 1'b1;
          end else if (accept && cmd.run) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          run_q <= 1'b1;
          if (accept && cmd.run) begin
            state_q <= ST_STOP;
            run_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_q <= ST_STOP;
          run_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_STOP;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_run      = run_q;
  assign bus.o_clear    = clear_q;
  assign bus.o_disp_sel = disp_q;
  assign bus.o_src_sel  = src_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Scoreboarded bench for stopwatch_cu with an 8-cycle command lockout.
module tb_stopwatch_cu;

  typedef struct packed {
    logic       btn_run;
    logic       btn_clear;
    logic       btn_mode;
    logic       rx_done;
    logic [7:0] rx_data;
  } stim_t;

  typedef struct packed {
    logic       run;
    logic       clear;
    logic       disp;
    logic       src;
    logic [1:0] state;
  } exp_t;

  localparam stim_t S_IDLE  = '{btn_run: 1'b0, btn_clear: 1'b0, btn_mode: 1'b0, rx_done: 1'b0, rx_data: 8'h00};
  localparam stim_t S_BRUN  = '{btn_run: 1'b1, btn_clear: 1'b0, btn_mode: 1'b0, rx_done: 1'b0, rx_data: 8'h00};
  localparam stim_t S_BCLR  = '{btn_run: 1'b0, btn_clear: 1'b1, btn_mode: 1'b0, rx_done: 1'b0, rx_data: 8'h00};
  localparam stim_t S_BMODE = '{btn_run: 1'b0, btn_clear: 1'b0, btn_mode: 1'b1, rx_done: 1'b0, rx_data: 8'h00};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  stopwatch_cu_if bus ();

  stopwatch_cu #(.CMD_GAP(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t rx(input logic [7:0] b);
    return '{btn_run: 1'b0, btn_clear: 1'b0, btn_mode: 1'b0, rx_done: 1'b1, rx_data: b};
  endfunction

  function automatic exp_t mk(input logic r, input logic c, input logic d, input logic s, input logic [1:0] st);
    return '{run: r, clear: c, disp: d, src: s, state: st};
  endfunction

  function automatic exp_t observed();
    return '{run: bus.o_run, clear: bus.o_clear, disp: bus.o_disp_sel, src: bus.o_src_sel, state: bus.o_state};
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input exp_t e);
    for (int i = 0; i < n; i++) push(S_IDLE, e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    bus.btn_run   = s.btn_run;
    bus.btn_clear = s.btn_clear;
    bus.btn_mode  = s.btn_mode;
    bus.rx_done   = s.rx_done;
    bus.rx_data   = s.rx_data;
    @(posedge clk);
    #1;
    bus.btn_run   = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_mode  = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    e = mk(0, 0, 0, 0, 2'b00);
    n_tests++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", observed(), e);
    end
    $display("[TB] reset_state checked out=%b", observed());
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_run_toggle();
    exp_t e;
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));
    push_idle(7, mk(1, 0, 0, 0, 2'b01));
    push(S_BRUN, mk(0, 0, 0, 0, 2'b00));
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL run_toggle step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] run_toggle step=%0d out=%b", step, observed());
    end
  endtask

  task automatic test_clear();
    exp_t e;
    push(rx(8'h63), mk(0, 1, 0, 0, 2'b10));
    push_idle(1, mk(0, 0, 0, 0, 2'b00));
    push_idle(6, mk(0, 0, 0, 0, 2'b00));
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));
    push_idle(7, mk(1, 0, 0, 0, 2'b01));
    push(S_BCLR, mk(1, 0, 0, 0, 2'b01));
    push_idle(7, mk(1, 0, 0, 0, 2'b01));
    push(S_BRUN, mk(0, 0, 0, 0, 2'b00));
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL clear step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] clear step=%0d out=%b", step, observed());
    end
  endtask

  task automatic test_simultaneous();
    exp_t  e;
    stim_t s;
    s = S_BCLR;
    s.btn_run = 1'b1;
    push(s, mk(0, 1, 0, 0, 2'b10));
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    s = rx(8'h6D);
    s.btn_mode = 1'b1;
    push(s, mk(0, 0, 1, 0, 2'b00));
    push_idle(7, mk(0, 0, 1, 0, 2'b00));
    push(S_BMODE, mk(0, 0, 0, 0, 2'b00));
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL simultaneous step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] simultaneous step=%0d out=%b", step, observed());
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));        // t0
    push_idle(2, mk(1, 0, 0, 0, 2'b01));
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));        // t0+3 dropped
    push_idle(3, mk(1, 0, 0, 0, 2'b01));
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));        // t0+7 last locked cycle
    push(S_BRUN, mk(0, 0, 0, 0, 2'b00));        // t0+8 accepted
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    push(rx(8'h41), mk(0, 0, 0, 0, 2'b00));     // unknown byte, no lockout
    push(rx(8'h52), mk(1, 0, 0, 0, 2'b01));
    push_idle(7, mk(1, 0, 0, 0, 2'b01));
    push(rx(8'h72), mk(0, 0, 0, 0, 2'b00));
    push_idle(7, mk(0, 0, 0, 0, 2'b00));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL lockout step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] lockout step=%0d out=%b", step, observed());
    end
  endtask

  task automatic test_src_view();
    exp_t e;
    push(rx(8'h4D), mk(0, 0, 0, 1, 2'b00));
    push_idle(7, mk(0, 0, 0, 1, 2'b00));
    push(rx(8'h6E), mk(0, 0, 1, 1, 2'b00));
    push_idle(7, mk(0, 0, 1, 1, 2'b00));
    push(S_BRUN, mk(1, 0, 1, 1, 2'b01));
    push_idle(7, mk(1, 0, 1, 1, 2'b01));
    push(rx(8'h4D), mk(1, 0, 1, 0, 2'b01));
    push_idle(7, mk(1, 0, 1, 0, 2'b01));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL src_view step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] src_view step=%0d out=%b", step, observed());
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    e = mk(0, 0, 0, 0, 2'b00);
    n_tests++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL reset_async got=%b want=%b", observed(), e);
    end else $display("[TB] reset_async out=%b", observed());
    @(negedge clk);
    reset = 1'b0;
    push(S_BRUN, mk(1, 0, 0, 0, 2'b01));
    for (int step = 0; stim_q.size() > 0; step++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL reset_first_cmd step=%0d got=%b want=%b", step, observed(), e);
      end else $display("[TB] reset_first_cmd step=%0d out=%b", step, observed());
    end
  endtask

  initial begin
    bus.btn_run   = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_mode  = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    test_reset();
    test_run_toggle();
    test_clear();
    test_simultaneous();
    test_lockout();
    test_src_view();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_cu.md
STOPWATCH_CU -- requirements
Module: stopwatch_cu

Interface
REQ-001 SHALL have parameter CMD_GAP, default 100_000, giving the clock cycles after an accepted command during which further commands are ignored (1 ms at 100 MHz).
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port btn_run, input, 1, debounced single-cycle pulse that toggles run/stop.
REQ-005 SHALL have port btn_clear, input, 1, debounced single-cycle pulse that clears the count.
REQ-006 SHALL have port btn_mode, input, 1, debounced single-cycle pulse that toggles the display view.
REQ-007 SHALL have port rx_data, input, 8, UART received byte.
REQ-008 SHALL have port rx_done, input, 1, single-cycle strobe; rx_data is valid while it is high.
REQ-009 SHALL have port o_run, output, 1, count-enable level to the stopwatch datapath.
REQ-010 SHALL have port o_clear, output, 1, single-cycle synchronous clear pulse to the datapath.
REQ-011 SHALL have port o_disp_sel, output, 1, display selector to the FND controller mode input: 0 = sec/msec, 1 = hour/min.
REQ-012 SHALL have port o_src_sel, output, 1, time source selector: 0 = stopwatch, 1 = watch.
REQ-013 SHALL have port o_state, output, 2, current FSM state encoding for debug.

Function
REQ-014 SHALL implement the states STOP=2'b00, RUN=2'b01 and CLEAR=2'b10; the code 2'b11 is illegal and SHALL return to STOP on the next clock.
REQ-015 SHALL produce the following internal commands:
- RUN_TGL from btn_run, or from rx_done with rx_data 'R' (8'h52) or 'r' (8'h72).
- CLR from btn_clear, or from rx_data 'C' (8'h43) or 'c' (8'h63).
- VIEW_TGL from btn_mode, or from rx_data 'N' (8'h4E) or 'n' (8'h6E).
- SRC_TGL from rx_data 'M' (8'h4D) or 'm' (8'h6D).
- Any other byte SHALL be ignored.
REQ-016 SHALL apply these transitions:
- STOP + RUN_TGL -> RUN.
- RUN + RUN_TGL -> STOP.
- STOP + CLR -> CLEAR.
- CLEAR -> STOP unconditionally after one cycle.
- CLR in RUN SHALL be ignored.
REQ-017 SHALL, when more than one command is present in the same cycle, accept exactly one using the priority CLR > RUN_TGL > VIEW_TGL > SRC_TGL and discard the others.
REQ-018 SHALL drive o_run high exactly while the state is RUN; it is a registered output and asserts one cycle after the accepted command.
REQ-019 SHALL drive o_clear high for exactly the one cycle the state is CLEAR; o_run SHALL be 0 in that cycle.
REQ-020 SHALL toggle o_disp_sel on an accepted VIEW_TGL in any state, one cycle after acceptance.
REQ-021 SHALL toggle o_src_sel on an accepted SRC_TGL in any state; o_run and the FSM state SHALL be unaffected, so the stopwatch keeps counting while the watch is shown.
REQ-022 SHALL load a gap counter with CMD_GAP-1 on every accepted command and decrement it to 0; all commands arriving while it is nonzero SHALL be dropped, not queued.
REQ-023 SHALL treat the gap counter as width $clog2(CMD_GAP), saturating at 0 with no wrap-around; when CMD_GAP=1 there is no lockout.
REQ-024 SHALL accept a command arriving in the cycle the gap counter reaches 0 as a normal accepted command.

Reset
REQ-025 SHALL, while reset is high, force the state to STOP, o_run=0, o_clear=0, o_disp_sel=0, o_src_sel=0, o_state=2'b00 and the gap counter=0, independent of clk.
REQ-026 SHALL, on reset asserted mid-RUN or mid-CLEAR, abort immediately with no o_clear pulse generated; the first command after deassertion is accepted without lockout.

Structure
REQ-027 SHALL take the state encodings and the eight ASCII command constants from a shared package, stopwatch_pkg, so that the datapath and the UART blocks use the same values.
REQ-028 SHALL contain one sub-module, cmd_decoder, which is combinational and maps the buttons and rx_data/rx_done to the four command pulses with the priority of REQ-017 applied.
REQ-029 SHALL keep all outputs registered, with no combinational path from any input to any output.

Verification
REQ-030 SHALL verify run toggling: reset, then btn_run pulse -> o_run=1 after 1 cycle and o_state=01; wait CMD_GAP cycles, btn_run pulse -> o_run=0 and o_state=00.
REQ-031 SHALL verify clear in STOP and RUN: in STOP, rx_done with 8'h63 -> o_clear high for exactly 1 cycle, then o_state=00; in RUN, btn_clear -> no o_clear pulse and o_run stays 1.
REQ-032 SHALL verify simultaneous commands: btn_clear and btn_run in the same cycle from STOP -> CLEAR taken, o_run stays 0; btn_mode and rx 'm' together -> only o_disp_sel toggles.
REQ-033 SHALL verify lockout with CMD_GAP=8: btn_run at t0, then btn_run at t0+3 -> ignored and o_run=1; btn_run at t0+8 -> accepted and o_run=0.
REQ-034 SHALL verify source and view toggling: rx 8'h4D then, after the gap, 8'h6E -> o_src_sel=1 and o_disp_sel=1, with o_run unchanged throughout.
REQ-035 SHALL verify reset mid-operation: assert reset while in RUN with o_disp_sel=1 -> all outputs 0 within the same cycle, with no clk edge required.
